// File: rtl/vmul_pkg.sv
// Shared types and lane helpers for the vector Vedic multiplier issue path.
package vmul_pkg;

  localparam int NUM_CHUNKS  = 4;
  localparam int CHUNK_WIDTH = 16;

  typedef enum logic [1:0] {
    OP_MUL   = 2'b00,
    OP_MULH  = 2'b01,
    OP_MULHU = 2'b10,
    OP_MULSU = 2'b11
  } opcode_e;

  typedef enum logic [1:0] {
    PREC_8  = 2'b00,
    PREC_16 = 2'b01,
    PREC_32 = 2'b10
  } prec_e;

  typedef struct packed {
    logic                  valid;
    logic [1:0]            opcode;
    logic [1:0]            precision;
    logic [NUM_CHUNKS-1:0] sign_a;
    logic [NUM_CHUNKS-1:0] sign_b;
  } ctl_t;

  // In 8-bit mode each byte's sign lands on the chunk with the same index.
  function automatic logic [NUM_CHUNKS-1:0] chunk_signs(input logic [31:0] v,
                                                        input logic [1:0]  prec,
                                                        input logic        is_signed);
    logic [NUM_CHUNKS-1:0] s;
    case (prec)
      PREC_16: s = {v[31], v[31], v[15], v[15]};
      PREC_32: s = {NUM_CHUNKS{v[31]}};
      default: s = {v[31], v[23], v[15], v[7]};
    endcase
    return is_signed ? s : '0;
  endfunction

  function automatic logic [31:0] lane_magnitude(input logic [31:0] v,
                                                 input logic [1:0]  prec,
                                                 input logic        is_signed);
    logic [31:0] m;
    m = v;
    if (is_signed) begin
      case (prec)
        PREC_16: begin
          for (int i = 0; i < 2; i++) begin
            if (v[16*i+15]) m[16*i +: 16] = -v[16*i +: 16];
          end
        end
        PREC_32: begin
          if (v[31]) m = -v;
        end
        default: begin
          for (int i = 0; i < 4; i++) begin
            if (v[8*i+7]) m[8*i +: 8] = -v[8*i +: 8];
          end
        end
      endcase
    end
    return m;
  endfunction

endpackage

// File: rtl/vmul_result_fifo.sv
// Small synchronous FIFO holding finished products until downstream takes them.
module vmul_result_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic             empty_o,
  output logic             full_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/vmul_issue_ctrl.sv
// Issue/sequencing controller for the Vedic multiplier core with credit-protected result FIFO.
// Define VMUL_ISSUE_PERF_CNT_EN to add the perf_issued/perf_stall counters.
module vmul_issue_ctrl
  import vmul_pkg::*;
#(
  parameter int unsigned MUL_LAT   = 2,
  parameter int unsigned OUT_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_opcode,
  input  logic [1:0]  in_precision,
  input  logic [31:0] in_operand_a,
  input  logic [31:0] in_operand_b,
  output logic        core_valid,
  output logic [31:0] core_operand_a,
  output logic [31:0] core_operand_b,
  output logic [1:0]  core_precision,
  output logic [1:0]  ctl_opcode,
  output logic [1:0]  ctl_precision,
  output logic [3:0]  ctl_sign_a,
  output logic [3:0]  ctl_sign_b,
  output logic        ctl_valid,
  input  logic [31:0] stage_result,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        busy
`ifdef VMUL_ISSUE_PERF_CNT_EN
  ,
  output logic [31:0] perf_issued,
  output logic [31:0] perf_stall
`endif
);

  localparam int unsigned CW = $clog2(OUT_DEPTH) + 1;
  localparam logic [CW-1:0] CREDIT_MAX = CW'(OUT_DEPTH);

  logic          accept, pop;
  logic          fifo_empty, fifo_full;
  logic [31:0]   fifo_head;
  logic [1:0]    prec_in;
  logic          signed_a, signed_b;
  logic [CW-1:0] credits_q, credits_d;
  logic          core_valid_q;
  logic [31:0]   core_a_q, core_a_d, core_b_q, core_b_d;
  logic [1:0]    core_prec_q;
  ctl_t          issue_ctl_q, issue_ctl_d;
  ctl_t          ctl_pipe_q [MUL_LAT];

  // No pop bypass: a freed slot only becomes a credit one cycle after the pop.
  assign in_ready = (credits_q < CREDIT_MAX);
  assign accept   = in_valid && in_ready;
  assign pop      = out_valid && out_ready;

  always_comb begin
    prec_in  = (in_precision == 2'b11) ? 2'b00 : in_precision;
    signed_a = (in_opcode != OP_MULHU);
    signed_b = (in_opcode == OP_MUL) || (in_opcode == OP_MULH);
    core_a_d = lane_magnitude(in_operand_a, prec_in, signed_a);
    core_b_d = lane_magnitude(in_operand_b, prec_in, signed_b);
    issue_ctl_d.valid     = accept;
    issue_ctl_d.opcode    = in_opcode;
    issue_ctl_d.precision = prec_in;
    issue_ctl_d.sign_a    = chunk_signs(in_operand_a, prec_in, signed_a);
    issue_ctl_d.sign_b    = chunk_signs(in_operand_b, prec_in, signed_b);
    credits_d = credits_q + CW'(accept) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      credits_q    <= '0;
      core_valid_q <= 1'b0;
      core_a_q     <= '0;
      core_b_q     <= '0;
      core_prec_q  <= '0;
      issue_ctl_q  <= '0;
    end else begin
      credits_q    <= credits_d;
      core_valid_q <= accept;
      if (accept) begin
        core_a_q    <= core_a_d;
        core_b_q    <= core_b_d;
        core_prec_q <= prec_in;
        issue_ctl_q <= issue_ctl_d;
      end else begin
        issue_ctl_q.valid <= 1'b0;
      end
    end
  end

  // Control sidebands ride alongside the core so they meet its product at the output stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MUL_LAT; i++) ctl_pipe_q[i] <= '0;
    end else begin
      ctl_pipe_q[0] <= issue_ctl_q;
      for (int i = 1; i < MUL_LAT; i++) ctl_pipe_q[i] <= ctl_pipe_q[i-1];
    end
  end

  assign core_valid     = core_valid_q;
  assign core_operand_a = core_a_q;
  assign core_operand_b = core_b_q;
  assign core_precision = core_prec_q;
  assign ctl_valid      = ctl_pipe_q[MUL_LAT-1].valid;
  assign ctl_opcode     = ctl_pipe_q[MUL_LAT-1].opcode;
  assign ctl_precision  = ctl_pipe_q[MUL_LAT-1].precision;
  assign ctl_sign_a     = ctl_pipe_q[MUL_LAT-1].sign_a;
  assign ctl_sign_b     = ctl_pipe_q[MUL_LAT-1].sign_b;

  vmul_result_fifo #(
    .DEPTH (OUT_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (ctl_valid),
    .push_data_i (stage_result),
    .pop_i       (pop),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full),
    .head_o      (fifo_head)
  );

  assign out_valid  = !fifo_empty;
  assign out_result = fifo_empty ? '0 : fifo_head;
  assign busy       = (credits_q != '0);

  // Credits bound the in-flight count, so a write into a full FIFO means a credit bug.
  assert property (@(posedge clk) disable iff (rst) !(ctl_valid && fifo_full));

`ifdef VMUL_ISSUE_PERF_CNT_EN
  logic [31:0] perf_issued_q, perf_stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_issued_q <= '0;
      perf_stall_q  <= '0;
    end else begin
      if (accept)               perf_issued_q <= perf_issued_q + 32'd1;
      if (in_valid && !in_ready) perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_issued = perf_issued_q;
  assign perf_stall  = perf_stall_q;
`endif

endmodule

// File: tb/tb_vmul_issue_ctrl.sv
// Randomized self-checking bench for vmul_issue_ctrl with a lane-arithmetic reference model
// and a fake core that folds aligned operands and control into a checkable result.
module tb_vmul_issue_ctrl;

  localparam int MUL_LAT   = 2;
  localparam int OUT_DEPTH = 4;

  typedef struct {
    int          cyc;
    logic [1:0]  op;
    logic [1:0]  prec;
    logic [31:0] magA;
    logic [31:0] magB;
    logic [3:0]  sa;
    logic [3:0]  sb;
    logic [31:0] res;
  } req_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [1:0]  in_opcode, in_precision;
  logic [31:0] in_operand_a, in_operand_b;
  logic        core_valid;
  logic [31:0] core_operand_a, core_operand_b;
  logic [1:0]  core_precision, ctl_opcode, ctl_precision;
  logic [3:0]  ctl_sign_a, ctl_sign_b;
  logic        ctl_valid;
  logic [31:0] stageResult;
  logic        out_valid, out_ready;
  logic [31:0] out_result;
  logic        busy;
`ifdef VMUL_ISSUE_PERF_CNT_EN
  logic [31:0] perfIssued, perfStall;
`endif

  int   checks = 0;
  int   errors = 0;
  int   cycleNow = 0;
  int   fires = 0;
  bit   lastFire = 1'b0;
  int   credits = 0;
  int   modelIssued = 0;
  int   modelStall = 0;
  req_t issueQ[$];
  req_t ctlQ[$];
  req_t resQ[$];
  logic [31:0] pipeA [MUL_LAT];
  logic [31:0] pipeB [MUL_LAT];

  always #5 clk = ~clk;

  vmul_issue_ctrl #(.MUL_LAT(MUL_LAT), .OUT_DEPTH(OUT_DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_opcode      (in_opcode),
    .in_precision   (in_precision),
    .in_operand_a   (in_operand_a),
    .in_operand_b   (in_operand_b),
    .core_valid     (core_valid),
    .core_operand_a (core_operand_a),
    .core_operand_b (core_operand_b),
    .core_precision (core_precision),
    .ctl_opcode     (ctl_opcode),
    .ctl_precision  (ctl_precision),
    .ctl_sign_a     (ctl_sign_a),
    .ctl_sign_b     (ctl_sign_b),
    .ctl_valid      (ctl_valid),
    .stage_result   (stageResult),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_result     (out_result),
    .busy           (busy)
`ifdef VMUL_ISSUE_PERF_CNT_EN
    ,
    .perf_issued    (perfIssued),
    .perf_stall     (perfStall)
`endif
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, actual, expected, cycleNow);
    end
  endtask

  function automatic logic [31:0] fakeCore(logic [31:0] pa, logic [31:0] pb, logic [1:0] op,
                                           logic [1:0] prec, logic [3:0] sa, logic [3:0] sb);
    return (pa * 32'h9E3779B1) ^ {pb[24:0], pb[31:25]} ^ {op, prec, sa, sb, 20'h5A5A5};
  endfunction

  function automatic logic [31:0] modelMag(logic [31:0] v, int w, bit sgn);
    logic [63:0] acc, lane, full;
    acc  = '0;
    full = 64'd1 << w;
    for (int l = 0; l < 32 / w; l++) begin
      lane = ({32'd0, v} >> (l * w)) % full;
      if (sgn && lane >= full / 2) lane = full - lane;
      acc = acc + (lane << (l * w));
    end
    return acc[31:0];
  endfunction

  function automatic logic [3:0] modelSigns(logic [31:0] v, int w, bit sgn);
    logic [3:0] s;
    int msb;
    s = '0;
    for (int c = 0; c < 4; c++) begin
      if (w == 8)       msb = 8 * c + 7;
      else if (w == 16) msb = 16 * (c / 2) + 15;
      else              msb = 31;
      s[c] = sgn && v[msb];
    end
    return s;
  endfunction

  function automatic req_t makeReq(logic [1:0] op, logic [1:0] prec, logic [31:0] a, logic [31:0] b, int cyc);
    req_t r;
    int w;
    bit sa, sb;
    r.cyc  = cyc;
    r.op   = op;
    r.prec = (prec == 2'b11) ? 2'b00 : prec;
    w  = (r.prec == 2'b01) ? 16 : (r.prec == 2'b10) ? 32 : 8;
    sa = (op != 2'b10);
    sb = (op == 2'b00) || (op == 2'b01);
    r.magA = modelMag(a, w, sa);
    r.magB = modelMag(b, w, sb);
    r.sa   = modelSigns(a, w, sa);
    r.sb   = modelSigns(b, w, sb);
    r.res  = fakeCore(r.magA, r.magB, op, r.prec, r.sa, r.sb);
    return r;
  endfunction

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(5))
      0:       return 32'h80808080;
      1:       return 32'hFFFFFFFF;
      2:       return 32'h80000000;
      3:       return 32'h7FFF8001;
      default: return $urandom();
    endcase
  endfunction

  // Fake Vedic core: fixed MUL_LAT delay on the magnitudes, folded with the aligned control.
  always @(posedge clk) begin
    pipeA[0] <= core_operand_a;
    pipeB[0] <= core_operand_b;
    for (int i = 1; i < MUL_LAT; i++) begin
      pipeA[i] <= pipeA[i-1];
      pipeB[i] <= pipeB[i-1];
    end
  end

  assign stageResult = ctl_valid ? fakeCore(pipeA[MUL_LAT-1], pipeB[MUL_LAT-1], ctl_opcode,
                                            ctl_precision, ctl_sign_a, ctl_sign_b)
                                 : 32'hDEADBEEF;

  always @(posedge clk) cycleNow <= cycleNow + 1;

  // Reference model: every request reappears at fixed offsets from its accept cycle.
  always @(negedge clk) begin
    req_t r;
    bit   expCore, expCtl, expOut, popNow, accNow;
    if (rst) begin
      issueQ.delete();
      ctlQ.delete();
      resQ.delete();
      credits     = 0;
      modelIssued = 0;
      modelStall  = 0;
    end else begin
      expCore = (issueQ.size() > 0) && (issueQ[0].cyc + 1 == cycleNow);
      checkOutput("core_valid", core_valid, expCore);
      if (expCore) begin
        r = issueQ.pop_front();
        checkOutput("core_operand_a", core_operand_a, r.magA);
        checkOutput("core_operand_b", core_operand_b, r.magB);
        checkOutput("core_precision", core_precision, r.prec);
      end
      expCtl = (ctlQ.size() > 0) && (ctlQ[0].cyc + 1 + MUL_LAT == cycleNow);
      checkOutput("ctl_valid", ctl_valid, expCtl);
      if (expCtl) begin
        r = ctlQ.pop_front();
        checkOutput("ctl_opcode", ctl_opcode, r.op);
        checkOutput("ctl_precision", ctl_precision, r.prec);
        checkOutput("ctl_sign_a", ctl_sign_a, r.sa);
        checkOutput("ctl_sign_b", ctl_sign_b, r.sb);
      end
      expOut = (resQ.size() > 0) && (resQ[0].cyc + 2 + MUL_LAT <= cycleNow);
      checkOutput("out_valid", out_valid, expOut);
      popNow = expOut && out_ready;
      if (popNow) begin
        r = resQ.pop_front();
        checkOutput("out_result", out_result, r.res);
      end
      checkOutput("in_ready", in_ready, credits < OUT_DEPTH);
      checkOutput("busy", busy, credits != 0);
      accNow = in_valid && (credits < OUT_DEPTH);
      if (in_valid && !(credits < OUT_DEPTH)) modelStall++;
      if (accNow) begin
        r = makeReq(in_opcode, in_precision, in_operand_a, in_operand_b, cycleNow);
        issueQ.push_back(r);
        ctlQ.push_back(r);
        resQ.push_back(r);
        modelIssued++;
      end
      credits = credits + int'(accNow) - int'(popNow);
    end
  end

  task automatic applyStimulus(input int validPct, input int readyPct, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (!in_valid || lastFire) begin
        in_valid     = ($urandom_range(99) < validPct);
        in_opcode    = 2'($urandom_range(3));
        in_precision = 2'($urandom_range(3));
        in_operand_a = pickOperand();
        in_operand_b = pickOperand();
      end
      out_ready = ($urandom_range(99) < readyPct);
      @(negedge clk);
      lastFire = in_valid && in_ready;
      if (lastFire) fires++;
    end
  endtask

  task automatic runDirected(input logic [1:0] op, input logic [1:0] prec, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] expA, input logic [31:0] expB,
                             input logic [1:0] expPrec, input logic [3:0] expSa, input logic [3:0] expSb);
    int n;
    @(posedge clk); #1;
    out_ready    = 1'b1;
    in_valid     = 1'b1;
    in_opcode    = op;
    in_precision = prec;
    in_operand_a = a;
    in_operand_b = b;
    @(negedge clk);
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n == 20) checkOutput("dir_accept", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lastFire = 1'b0;
    @(negedge clk);
    checkOutput("dir_core_a", core_operand_a, expA);
    checkOutput("dir_core_b", core_operand_b, expB);
    checkOutput("dir_core_prec", core_precision, expPrec);
    repeat (MUL_LAT) @(negedge clk);
    checkOutput("dir_sign_a", ctl_sign_a, expSa);
    checkOutput("dir_sign_b", ctl_sign_b, expSb);
    checkOutput("dir_out_early", out_valid, 0);
    @(negedge clk);
    checkOutput("dir_out_latency", out_valid, 1);
    checkOutput("dir_result", out_result, fakeCore(expA, expB, op, expPrec, expSa, expSb));
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_opcode = '0;
    in_precision = '0;
    in_operand_a = '0;
    in_operand_b = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_in_ready", in_ready, 1);
    checkOutput("rst_core_valid", core_valid, 0);
    checkOutput("rst_ctl_valid", ctl_valid, 0);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_core_a", core_operand_a, 0);
    checkOutput("rst_core_b", core_operand_b, 0);
    checkOutput("rst_ctl_fields", {ctl_opcode, ctl_precision, ctl_sign_a, ctl_sign_b}, 0);
    checkOutput("rst_out_result", out_result, 0);
`ifdef VMUL_ISSUE_PERF_CNT_EN
    checkOutput("rst_perf_issued", perfIssued, 0);
    checkOutput("rst_perf_stall", perfStall, 0);
`endif

    runDirected(2'b01, 2'b10, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'h00000002, 2'b10, 4'b1111, 4'b0000);
    runDirected(2'b10, 2'b10, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'h00000002, 2'b10, 4'b0000, 4'b0000);
    runDirected(2'b00, 2'b00, 32'h80FF7F03, 32'h01FF0202, 32'h80017F03, 32'h01010202, 2'b00, 4'b1100, 4'b0100);
    runDirected(2'b11, 2'b01, 32'h8000FFFE, 32'hFFFF0001, 32'h80000002, 32'hFFFF0001, 2'b01, 4'b1111, 4'b0000);
    runDirected(2'b00, 2'b11, 32'h80FF7F03, 32'h01FF0202, 32'h80017F03, 32'h01010202, 2'b00, 4'b1100, 4'b0100);

    fires = 0;
    applyStimulus(100, 0, 10);
    checkOutput("bp_accepts", fires, OUT_DEPTH);
    checkOutput("bp_in_ready_low", in_ready, 0);
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    lastFire  = 1'b0;
    @(negedge clk);
    checkOutput("bp_first_pop", out_valid, 1);
    checkOutput("bp_ready_in_pop_cycle", in_ready, 0);
    @(negedge clk);
    checkOutput("bp_ready_after_pop", in_ready, 1);
    applyStimulus(0, 100, 10);

    applyStimulus(60, 70, 400);
    applyStimulus(0, 100, 20);

    applyStimulus(100, 0, 3);
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    lastFire = 1'b0;
    @(negedge clk);
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_out_valid", out_valid, 0);
    checkOutput("midrst_in_ready", in_ready, 1);
`ifdef VMUL_ISSUE_PERF_CNT_EN
    checkOutput("midrst_perf_issued", perfIssued, 0);
    checkOutput("midrst_perf_stall", perfStall, 0);
`endif
    applyStimulus(0, 100, 10);

    applyStimulus(50, 50, 200);
    applyStimulus(0, 100, 20);
    checkOutput("final_busy", busy, 0);
`ifdef VMUL_ISSUE_PERF_CNT_EN
    checkOutput("final_perf_issued", perfIssued, modelIssued);
    checkOutput("final_perf_stall", perfStall, modelStall);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
